// File: rtl/clk_div_channel.sv
// One divided-clock channel. Even ratios use a single toggling flop; odd ratios
// combine a rising-edge flop with a falling-edge copy to get a half-cycle-exact 50% duty.
module clk_div_channel #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic nrst,
    output logic clk_out
);

    localparam int            CW       = (DIV < 3) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam bit            IS_ODD   = (DIV % 2) == 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (DIV < 2) begin : g_bad_div
            $error("clk_div_channel: DIV must be >= 2");
        end

        if (!IS_ODD) begin : g_even
            localparam logic [CW-1:0] CNT_MID = CW'(DIV / 2 - 1);

            logic out_q, out_d;

            // Toggle on the count being entered, so the first rise lands on edge 1.
            always_comb begin
                out_d = out_q;
                if ((cnt_d == CNT_MID) || (cnt_d == CNT_LAST)) begin
                    out_d = ~out_q;
                end
            end

            always_ff @(posedge clk) begin
                if (nrst) begin
                    out_q <= 1'b0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign clk_out = out_q;
        end else begin : g_odd
            localparam logic [CW-1:0] P_LEN = CW'((DIV - 1) / 2);

            logic p_q, p_d;
            logic n_q, n_d;

            always_comb begin
                p_d = (cnt_q < P_LEN);
                n_d = p_q;
            end

            always_ff @(posedge clk) begin
                if (nrst) begin
                    p_q <= 1'b0;
                end else begin
                    p_q <= p_d;
                end
            end

            // Half-cycle extension; clears itself one falling edge after p drops.
            always_ff @(negedge clk) begin
                n_q <= n_d;
            end

            assign clk_out = p_q | n_q;
        end
    endgenerate

endmodule

// File: rtl/clk_div_pair.sv
// Dual fixed-ratio clock divider: out2 at clk/DIV_A and out3 at clk/DIV_B,
// both 50% duty and phase-aligned on the first rising edge after reset release.
module clk_div_pair #(
    parameter int DIV_A = 2,
    parameter int DIV_B = 3
) (
    input  logic clk,
    input  logic nrst,
    output logic out2,
    output logic out3
);

    clk_div_channel #(
        .DIV (DIV_A)
    ) u_chan_a (
        .clk     (clk),
        .nrst    (nrst),
        .clk_out (out2)
    );

    clk_div_channel #(
        .DIV (DIV_B)
    ) u_chan_b (
        .clk     (clk),
        .nrst    (nrst),
        .clk_out (out3)
    );

endmodule

// File: tb/tb_clk_div_pair.sv
// Bench for clk_div_pair: default (2,3) and swept (4,5) instances checked at every
// half cycle against a half-cycle-phase reference model through an expected queue.
module tb_clk_div_pair;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic out2_a, out3_a, out2_b, out3_b;

    clk_div_pair #(.DIV_A(2), .DIV_B(3)) dut_a (
        .clk  (clk),
        .nrst (nrst),
        .out2 (out2_a),
        .out3 (out3_a)
    );

    clk_div_pair #(.DIV_A(4), .DIV_B(5)) dut_b (
        .clk  (clk),
        .nrst (nrst),
        .out2 (out2_b),
        .out3 (out3_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    // entry: [0] out2_a [1] out3_a [2] care out3_a [3] out2_b [4] out3_b [5] care out3_b [6] window
    localparam int W = 7;
    logic [W-1:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    int edge_k = 0;
    int win_hi[4];

    // A ratio-d clock is high for d half-cycles out of every 2d, starting at edge 1.
    function automatic bit ref_hi(input int d, input int h);
        return (h % (2 * d)) < d;
    endfunction

    function automatic logic [W-1:0] ref_entry(input int h, input bit win);
        return {win, 1'b1, ref_hi(5, h), ref_hi(4, h), 1'b1, ref_hi(3, h), ref_hi(2, h)};
    endfunction

    // driver: sets nrst for the coming rising edge and queues the two half-cycle expectations
    task automatic drive_cycle(input bit rst, input bit win);
        logic [W-1:0] e_rise, e_fall;
        @(negedge clk);
        #2;
        nrst   = rst;
        mon_en = 1'b1;
        if (rst) begin
            edge_k = 0;
            e_rise = '0;
            e_fall = '0;
            e_fall[2] = 1'b1;
            e_fall[5] = 1'b1;
            e_rise[6] = win;
            e_fall[6] = win;
        end else begin
            edge_k = edge_k + 1;
            e_rise = ref_entry(2 * (edge_k - 1), win);
            e_fall = ref_entry(2 * (edge_k - 1) + 1, win);
        end
        exp_q.push_back(e_rise);
        exp_q.push_back(e_fall);
    endtask

    // scoreboard
    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic sample_check();
        logic [W-1:0] e;
        if (!mon_en) return;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL exp_q_underflow at %0t: got empty expected entry", $time);
            return;
        end
        e = exp_q.pop_front();
        check_bit("out2_div2", out2_a, e[0]);
        if (e[2]) check_bit("out3_div3", out3_a, e[1]);
        check_bit("out2_div4", out2_b, e[3]);
        if (e[5]) check_bit("out3_div5", out3_b, e[4]);
        if (e[6]) begin
            if (out2_a) win_hi[0]++;
            if (out3_a) win_hi[1]++;
            if (out2_b) win_hi[2]++;
            if (out3_b) win_hi[3]++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            sample_check();
            @(negedge clk);
            #1;
            sample_check();
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) win_hi[i] = 0;
        nrst = 1'b1;

        // reset hold
        repeat (3) drive_cycle(1'b1, 1'b0);
        // release and 60-cycle duty window
        repeat (60) drive_cycle(1'b0, 1'b1);
        // mid-run reset on edge 5 after a fresh release
        drive_cycle(1'b1, 1'b0);
        repeat (4) drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0);
        // random reset pulses
        repeat (300) drive_cycle($urandom_range(0, 19) == 0, 1'b0);
        nrst = 1'b0;

        @(posedge clk);
        @(negedge clk);
        #3;
        mon_en = 1'b0;

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL exp_q_drain: got %0d entries left expected 0", exp_q.size());
        end
        // 60 cycles = 120 half-cycle samples, half of them high for every ratio here
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (win_hi[i] != 60) begin
                fails++;
                $display("FAIL duty_window_%0d: got %0d high half-cycles expected 60", i, win_hi[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
